// File: rtl/apb_reg_slave.sv
// APB register-file slave with SETUP/ACCESS sequencing and WAIT_ST programmable wait states.
// Define APB_SLVERR_EN to answer invalid (misaligned or out-of-range) addresses with Pslverr.
module apb_reg_slave #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = 3,
  parameter int SEL_IDX  = 0,
  parameter int WAIT_ST  = 0,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic                       Pclk,
  input  logic                       Preset,
  input  logic [SEL_W-1:0]           Pselx,
  input  logic                       Penable,
  input  logic                       Pwrite,
  input  logic [ADDR_W-1:0]          Paddr,
  input  logic [DATA_W-1:0]          Pwdata,
  output logic [DATA_W-1:0]          Prdata,
  output logic                       Pready,
  output logic                       Pslverr,
  output logic [NUM_REGS*DATA_W-1:0] Pregs
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(4 * NUM_REGS);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t              state;
  state_t              nextState;
  logic [3:0]          waitCnt;
  logic [ADDR_W-1:0]   latAddr;
  logic                latWrite;
  logic [DATA_W-1:0]   latWdata;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic                sel;
  logic                latchEn;
  logic                addrValid;
  logic [IDX_W-1:0]    idx;
  logic                commit;

  // Only one select bit belongs to this slave; the rest exist for the shared bus.
  logic unusedSel;
  assign unusedSel = ^Pselx;

  assign sel       = Pselx[SEL_IDX];
  assign idx       = latAddr[2 +: IDX_W];
  assign addrValid = (latAddr[1:0] == 2'b00) && ({1'b0, latAddr} < ADDR_LIMIT);
  assign Pready    = (state == ACCESS) && (waitCnt == 4'(WAIT_ST));
  assign commit    = Pready && latWrite && addrValid;

  always_comb begin
    nextState = state;
    latchEn   = 1'b0;
    case (state)
      IDLE: begin
        if (sel && !Penable) begin
          nextState = SETUP;
          latchEn   = 1'b1;
        end
      end
      SETUP: begin
        if (!sel)
          nextState = IDLE;
        else if (Penable)
          nextState = ACCESS;
      end
      ACCESS: begin
        // A fresh SETUP seen on the completing edge chains straight into the next transfer.
        if (Pready) begin
          if (sel && !Penable) begin
            nextState = SETUP;
            latchEn   = 1'b1;
          end else begin
            nextState = IDLE;
          end
        end else if (!sel) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge Pclk or posedge Preset) begin
    if (Preset) begin
      state    <= IDLE;
      waitCnt  <= '0;
      latAddr  <= '0;
      latWrite <= 1'b0;
      latWdata <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RST_VAL;
    end else begin
      state <= nextState;
      if (latchEn) begin
        latAddr  <= Paddr;
        latWrite <= Pwrite;
        latWdata <= Pwdata;
      end
      if (state == SETUP)
        waitCnt <= '0;
      else if (state == ACCESS && !Pready)
        waitCnt <= waitCnt + 4'd1;
      if (commit)
        regs[idx] <= latWdata;
    end
  end

  always_comb begin
    Prdata = '0;
    if (Pready && !latWrite && addrValid)
      Prdata = regs[idx];
  end

`ifdef APB_SLVERR_EN
  assign Pslverr = Pready && !addrValid;
`else
  assign Pslverr = 1'b0;
`endif

  for (genvar g = 0; g < NUM_REGS; g++) begin : gPregs
    assign Pregs[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench: slave 0 (Pselx[0], no wait states) and slave 1 (Pselx[1], three wait states)
// share one APB bus; expected values are written out by hand.
module tb_apb_reg_slave;

  localparam logic ERR_EN =
`ifdef APB_SLVERR_EN
    1'b1;
`else
    1'b0;
`endif

  logic         Pclk;
  logic         Preset;
  logic [2:0]   Pselx;
  logic         Penable;
  logic         Pwrite;
  logic [31:0]  Paddr;
  logic [31:0]  Pwdata;
  logic [31:0]  rdata0, rdata1;
  logic         ready0, ready1;
  logic         err0, err1;
  logic [255:0] regs0, regs1;

  int checks   = 0;
  int failures = 0;

  apb_reg_slave #(.SEL_IDX(0), .WAIT_ST(0)) u0 (
    .Pclk(Pclk), .Preset(Preset), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(rdata0), .Pready(ready0), .Pslverr(err0),
    .Pregs(regs0)
  );

  apb_reg_slave #(.SEL_IDX(1), .WAIT_ST(3)) u1 (
    .Pclk(Pclk), .Preset(Preset), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(rdata1), .Pready(ready1), .Pslverr(err1),
    .Pregs(regs1)
  );

  always #5 Pclk = ~Pclk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // One complete transfer on slave s; returns data/error seen while Pready was high,
  // the number of ACCESS cycles with Pready low, and the target register at that moment.
  task automatic applyStimulus(input int s, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, output logic [31:0] rdata,
                               output int waits, output logic err,
                               output logic [31:0] regAtReady);
    logic gotReady;
    int   ri;
    ri = int'(addr[4:2]);
    rdata = '0;
    err = 1'b0;
    regAtReady = '0;
    @(posedge Pclk); #1;
    Pselx = 3'b000;
    Pselx[s] = 1'b1;
    Penable = 1'b0;
    Pwrite = wr;
    Paddr = addr;
    Pwdata = data;
    @(posedge Pclk); #1;
    Penable = 1'b1;
    @(posedge Pclk); #1;
    waits = 0;
    gotReady = 1'b0;
    for (int c = 0; c < 40 && !gotReady; c++) begin
      if ((s == 1) ? ready1 : ready0) begin
        gotReady = 1'b1;
        rdata = (s == 1) ? rdata1 : rdata0;
        err = (s == 1) ? err1 : err0;
        regAtReady = (s == 1) ? regs1[ri*32 +: 32] : regs0[ri*32 +: 32];
      end else begin
        waits++;
        @(posedge Pclk); #1;
      end
    end
    if (!gotReady) checkOutput("readyTimeout", 32'd0, 32'd1);
    @(posedge Pclk); #1;
    checkOutput("readyOneCycle", {31'b0, (s == 1) ? ready1 : ready0}, 32'd0);
    Pselx = 3'b000;
    Penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0]  rd;
    logic [31:0]  regSnap;
    logic         err;
    int           waits;
    logic [255:0] snap;

    Pclk = 1'b0;
    Preset = 1'b1;
    Pselx = 3'b000;
    Penable = 1'b0;
    Pwrite = 1'b0;
    Paddr = '0;
    Pwdata = '0;
    #12;
    checkOutput("rstReady", {31'b0, ready0}, 32'd0);
    checkOutput("rstRdata", rdata0, 32'd0);
    checkOutput("rstErr", {31'b0, err0}, 32'd0);
    checkOutput("rstRegs", {31'b0, regs0 == 256'd0}, 32'd1);
    @(posedge Pclk); #1;
    Preset = 1'b0;

    $display("[TB] reset-value reads on all registers");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1'b0, 32'(i * 4), 32'd0, rd, waits, err, regSnap);
      checkOutput("rstRead", rd, 32'd0);
      checkOutput("rstReadWaits", 32'(waits), 32'd0);
    end

    $display("[TB] zero-wait write then read at 0x08");
    applyStimulus(0, 1'b1, 32'h08, 32'hDEADBEEF, rd, waits, err, regSnap);
    checkOutput("wr08Waits", 32'(waits), 32'd0);
    checkOutput("wr08Reg", regs0[95:64], 32'hDEADBEEF);
    applyStimulus(0, 1'b0, 32'h08, 32'd0, rd, waits, err, regSnap);
    checkOutput("rd08Data", rd, 32'hDEADBEEF);
    checkOutput("rd08Err", {31'b0, err}, 32'd0);

    $display("[TB] enable without SETUP is ignored");
    @(posedge Pclk); #1;
    Pselx = 3'b001; Penable = 1'b1; Pwrite = 1'b1; Paddr = 32'h08; Pwdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(posedge Pclk); #1;
      checkOutput("noSetupReady", {31'b0, ready0}, 32'd0);
    end
    Pselx = 3'b000; Penable = 1'b0;
    checkOutput("noSetupReg", regs0[95:64], 32'hDEADBEEF);

    $display("[TB] three wait states write at 0x04");
    applyStimulus(1, 1'b1, 32'h04, 32'h12345678, rd, waits, err, regSnap);
    checkOutput("ws3Waits", 32'(waits), 32'd3);
    checkOutput("ws3RegBeforeEdge", regSnap, 32'd0);
    checkOutput("ws3RegAfter", regs1[63:32], 32'h12345678);
    applyStimulus(1, 1'b0, 32'h04, 32'd0, rd, waits, err, regSnap);
    checkOutput("ws3Read", rd, 32'h12345678);
    checkOutput("ws3Slave0Untouched", regs0[63:32], 32'd0);

    $display("[TB] back-to-back writes to 0x00 and 0x1C");
    @(posedge Pclk); #1;
    Pselx = 3'b001; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h00; Pwdata = 32'hA0A00001;
    @(posedge Pclk); #1;
    Penable = 1'b1;
    @(posedge Pclk); #1;
    checkOutput("b2bReady1", {31'b0, ready0}, 32'd1);
    Penable = 1'b0; Paddr = 32'h1C; Pwdata = 32'hC0DE0007;
    @(posedge Pclk); #1;
    checkOutput("b2bSetup", {31'b0, ready0}, 32'd0);
    checkOutput("b2bReg0", regs0[31:0], 32'hA0A00001);
    Penable = 1'b1;
    @(posedge Pclk); #1;
    checkOutput("b2bReady2", {31'b0, ready0}, 32'd1);
    @(posedge Pclk); #1;
    Pselx = 3'b000; Penable = 1'b0;
    checkOutput("b2bReg7", regs0[255:224], 32'hC0DE0007);
    checkOutput("b2bReg0Kept", regs0[31:0], 32'hA0A00001);

    $display("[TB] invalid addresses 0x20 and 0x02");
    snap = regs0;
    applyStimulus(0, 1'b1, 32'h20, 32'h0000FFFF, rd, waits, err, regSnap);
    checkOutput("oorWrErr", {31'b0, err}, {31'b0, ERR_EN});
    checkOutput("oorWrRegs", {31'b0, regs0 == snap}, 32'd1);
    applyStimulus(0, 1'b1, 32'h02, 32'h0000FFFF, rd, waits, err, regSnap);
    checkOutput("misWrErr", {31'b0, err}, {31'b0, ERR_EN});
    checkOutput("misWrRegs", {31'b0, regs0 == snap}, 32'd1);
    applyStimulus(0, 1'b0, 32'h02, 32'd0, rd, waits, err, regSnap);
    checkOutput("misRdData", rd, 32'd0);
    checkOutput("misRdErr", {31'b0, err}, {31'b0, ERR_EN});
    applyStimulus(0, 1'b0, 32'h20, 32'd0, rd, waits, err, regSnap);
    checkOutput("oorRdData", rd, 32'd0);

    $display("[TB] reset during a waited write to 0x0C");
    @(posedge Pclk); #1;
    Pselx = 3'b010; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h0C; Pwdata = 32'hA5A5A5A5;
    @(posedge Pclk); #1;
    Penable = 1'b1;
    @(posedge Pclk); #1;
    @(posedge Pclk); #1;
    checkOutput("preRstReady", {31'b0, ready1}, 32'd0);
    #2 Preset = 1'b1;
    #1;
    checkOutput("midRstReady", {31'b0, ready1}, 32'd0);
    checkOutput("midRstReg3", regs1[127:96], 32'd0);
    checkOutput("midRstReg1", regs1[63:32], 32'd0);
    checkOutput("midRstSlave0", {31'b0, regs0 == 256'd0}, 32'd1);
    Pselx = 3'b000; Penable = 1'b0;
    @(posedge Pclk); #1;
    checkOutput("heldRstReady", {31'b0, ready1}, 32'd0);
    Preset = 1'b0;
    checkOutput("postRstReg3", regs1[127:96], 32'd0);
    applyStimulus(1, 1'b0, 32'h0C, 32'd0, rd, waits, err, regSnap);
    checkOutput("postRstRead", rd, 32'd0);
    checkOutput("postRstWaits", 32'(waits), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
